// File: rtl/conv_stream_kxk_if.sv
// Pixel/weight stream bundle for conv_stream_kxk: weight write port, input pixel stream,
// and convolved output stream with frame marker.
interface conv_stream_kxk_if #(
  parameter int DW = 8,
  parameter int WW = 8,
  parameter int K  = 5
);
  localparam int AW = $clog2(K * K);

  logic                 w_we;
  logic [AW-1:0]        w_addr;
  logic signed [WW-1:0] w_data;
  logic                 in_valid;
  logic [DW-1:0]        pxl_in;
  logic                 out_valid;
  logic [DW-1:0]        pxl_out;
  logic                 frame_done;

  modport master (
    output w_we, w_addr, w_data, in_valid, pxl_in,
    input  out_valid, pxl_out, frame_done
  );

  modport slave (
    input  w_we, w_addr, w_data, in_valid, pxl_in,
    output out_valid, pxl_out, frame_done
  );
endinterface

// File: rtl/conv_stream_kxk.sv
// Streaming KxK convolution over a raster-order DIMxDIM frame: line buffers feed a KxK window,
// then a registered MAC stage and a registered shift/clamp stage (latency 2 from the accepting edge).
module conv_stream_kxk #(
  parameter int DW     = 8,
  parameter int WW     = 8,
  parameter int DIM    = 28,
  parameter int K      = 5,
  parameter int STRIDE = 1,
  parameter int SHIFT  = 8
) (
  input logic              clk,
  input logic              reset,
  conv_stream_kxk_if.slave bus
);
  localparam int NW   = K * K;
  localparam int AW   = $clog2(NW);
  localparam int CW   = $clog2(DIM);
  // The reset centre weight is 2**SHIFT, which may not fit in WW bits, so storage is widened.
  localparam int WI   = (WW > SHIFT + 1) ? WW : SHIFT + 2;
  localparam int ACCW = DW + WI + 1 + $clog2(NW);
  localparam int CTR  = (NW - 1) / 2;
  localparam int LAST = (K - 1) + ((DIM - K) / STRIDE) * STRIDE;

  localparam logic signed [WI-1:0]   W_CTR = WI'(1 << SHIFT);
  localparam logic signed [ACCW-1:0] PMAX  = ACCW'((1 << DW) - 1);

  logic [CW-1:0]          col, row;
  logic [DW-1:0]          lb  [K-1][DIM];
  logic [DW-1:0]          win [K][K];
  logic [DW-1:0]          tap [K];
  logic signed [WI-1:0]   w   [NW];
  logic                   v0, d0, v1, d1;
  logic signed [ACCW-1:0] acc, mac_sum, shifted;
  logic [DW-1:0]          clamp_val;
  logic                   pos_ok, pos_last;

  // Column taps at the current column: tap[K-1] is the incoming pixel, tap[0] the oldest row.
  always_comb begin
    for (int k = 0; k < K - 1; k++) tap[k] = lb[k][col];
    tap[K-1] = bus.pxl_in;
  end

  // K is odd, so (row-(K-1)) has the same parity as row; stride 2 keeps even positions only.
  always_comb begin
    pos_ok   = (row >= CW'(K - 1)) && (col >= CW'(K - 1)) &&
               ((STRIDE == 1) || (!row[0] && !col[0]));
    pos_last = (row == CW'(LAST)) && (col == CW'(LAST));
  end

  always_comb begin
    mac_sum = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        mac_sum = mac_sum + ACCW'($signed({1'b0, win[i][j]})) * ACCW'(w[i*K+j]);
      end
    end
  end

  always_comb begin
    shifted = acc >>> SHIFT;
    if (shifted[ACCW-1])      clamp_val = '0;
    else if (shifted > PMAX)  clamp_val = '1;
    else                      clamp_val = shifted[DW-1:0];
  end

  // Window and line-buffer data are never reset; validity bits mask stale contents.
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      for (int k = 0; k < K - 1; k++) lb[k][col] <= tap[k+1];
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) win[i][j] <= win[i][j+1];
        win[i][K-1] <= tap[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col            <= '0;
      row            <= '0;
      v0             <= 1'b0;
      d0             <= 1'b0;
      v1             <= 1'b0;
      d1             <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.pxl_out    <= '0;
      for (int n = 0; n < NW; n++) w[n] <= (n == CTR) ? W_CTR : '0;
    end else begin
      if (bus.in_valid) begin
        if (col == CW'(DIM - 1)) begin
          col <= '0;
          row <= (row == CW'(DIM - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      v0 <= bus.in_valid && pos_ok;
      d0 <= bus.in_valid && pos_ok && pos_last;
      v1 <= v0;
      d1 <= d0;
      if (v0) acc <= mac_sum;

      bus.out_valid  <= v1;
      bus.frame_done <= d1;
      if (v1) bus.pxl_out <= clamp_val;

      if (bus.w_we && (bus.w_addr < AW'(NW))) w[bus.w_addr] <= WI'(bus.w_data);
    end
  end
endmodule
